// File: rtl/bus_responder85.sv
`default_nettype none
// ============================================================================
// Module   : bus_responder85
// Brief    : 8085 target-side bus responder with byte RAM, one I/O port,
//            INTA opcode return and programmable READY wait states.
// Revision : 1.0
// ============================================================================
module bus_responder85 #(
  parameter int          MEMAW   = 8,
  parameter logic [15:0] MEMBASE = 16'h0000,
  parameter logic [7:0]  IOPORT  = 8'h10,
  parameter int          WAITCNT = 0,
  parameter logic [7:0]  INTOP   = 8'hFF
) (
  input  logic       clk_,
  input  logic       rst_,
  input  logic [7:0] a_hi,
  input  logic [7:0] ad_i,
  output logic [7:0] ad_o,
  output logic       ad_oe,
  input  logic       ale,
  input  logic       iom_,
  input  logic       rd_,
  input  logic       wr_,
  input  logic       inta_,
  output logic       ready,
  input  logic [7:0] dev_in,
  output logic [7:0] dev_out,
  output logic       dev_stb
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_XFER = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  // The ADDR clock already holds READY low, so WAIT covers the remaining WAITCNT-1 clocks.
  localparam bit         c_has_wait  = (WAITCNT > 0);
  localparam bit         c_long_wait = (WAITCNT > 1);
  localparam logic [3:0] c_wait_load = c_long_wait ? 4'(WAITCNT - 2) : 4'd0;

  state_t           r_state;
  logic [15:0]      r_addr;
  logic             r_iom;
  logic [3:0]       r_cnt;
  logic [7:0]       r_wdata;
  logic             r_wpend;
  logic [7:0]       r_ad_o;
  logic             r_ad_oe;
  logic [7:0]       r_dev_out;
  logic             r_dev_stb;
  logic [7:0]       r_mem [0:(1<<MEMAW)-1];

  logic             w_cmd;
  logic             w_mem_hit;
  logic             w_io_hit;
  logic             w_hit;
  logic             w_release;
  logic             w_commit_mem;
  logic [MEMAW-1:0] w_ram_addr;
  logic [7:0]       w_rd_data;

  assign w_cmd        = ~rd_ | ~wr_ | ~inta_;
  assign w_mem_hit    = ~r_iom & (r_addr[15:MEMAW] == MEMBASE[15:MEMAW]);
  assign w_io_hit     = r_iom & (r_addr[7:0] == IOPORT);
  assign w_hit        = ~inta_ | w_mem_hit | w_io_hit;
  assign w_release    = rd_ & wr_ & inta_;
  assign w_ram_addr   = r_addr[MEMAW-1:0];
  assign w_rd_data    = ~inta_ ? INTOP : (r_iom ? dev_in : r_mem[w_ram_addr]);
  assign w_commit_mem = rst_ & ~ale & (r_state == S_XFER) & w_release & r_wpend & w_mem_hit;

  assign ready   = ~(((r_state == S_ADDR) & w_cmd & w_hit & c_has_wait) | (r_state == S_WAIT));
  assign ad_o    = r_ad_o;
  assign ad_oe   = r_ad_oe;
  assign dev_out = r_dev_out;
  assign dev_stb = r_dev_stb;

  always_ff @(posedge clk_) begin
    if (w_commit_mem) begin
      r_mem[w_ram_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk_) begin
    if (!rst_) begin
      r_state   <= S_IDLE;
      r_addr    <= 16'h0000;
      r_iom     <= 1'b0;
      r_cnt     <= 4'd0;
      r_wdata   <= 8'h00;
      r_wpend   <= 1'b0;
      r_ad_o    <= 8'h00;
      r_ad_oe   <= 1'b0;
      r_dev_out <= 8'h00;
      r_dev_stb <= 1'b0;
    end else begin
      r_dev_stb <= 1'b0;
      if (ale) begin
        // A new address phase aborts whatever was in flight, including a pending write.
        r_addr  <= {a_hi, ad_i};
        r_iom   <= iom_;
        r_state <= S_ADDR;
        r_ad_oe <= 1'b0;
        r_wpend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ad_oe <= 1'b0;
          end
          S_ADDR: begin
            if (w_cmd) begin
              if (!w_hit) begin
                r_state <= S_SKIP;
              end else if (c_long_wait) begin
                r_state <= S_WAIT;
                r_cnt   <= c_wait_load;
              end else begin
                r_state <= S_XFER;
              end
            end
          end
          S_WAIT: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_XFER;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_XFER: begin
            if (w_release) begin
              r_state <= S_IDLE;
              r_ad_oe <= 1'b0;
              r_wpend <= 1'b0;
              if (r_wpend && w_io_hit) begin
                r_dev_out <= r_wdata;
                r_dev_stb <= 1'b1;
              end
            end else if (!rd_ || !inta_) begin
              // rd_ and wr_ low together behaves as a read and forfeits the write.
              r_ad_oe <= 1'b1;
              r_ad_o  <= w_rd_data;
              r_wpend <= 1'b0;
            end else begin
              r_wdata <= ad_i;
              r_wpend <= 1'b1;
            end
          end
          S_SKIP: begin
            if (!w_cmd) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_responder85.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_responder85
// Brief    : Randomized bus-cycle bench for bus_responder85 (WAITCNT 0 and 3).
// Revision : 1.0
// ============================================================================
module tb_bus_responder85;

  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_IORD = 2;
  localparam int K_IOWR = 3;
  localparam int K_INTA = 4;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic [7:0] a_hi = 8'h00, ad_i = 8'h00, dev_in = 8'h00;
  logic       ale = 1'b0, iom_ = 1'b0, rd_ = 1'b1, wr_ = 1'b1, inta_ = 1'b1;

  logic [7:0] ad_o0, ad_o3, dev_out0, dev_out3;
  logic       ad_oe0, ad_oe3, ready0, ready3, dev_stb0, dev_stb3;

  // expectations for the current clock period
  logic       chk_en = 1'b0;
  logic       exp_rdy0, exp_rdy3, exp_oe0, exp_oe3, exp_stb, exp_known;
  logic [7:0] exp_data, exp_dev;

  // reference state
  logic [7:0] ram [0:255];
  bit         known [0:255];
  bit         pend_abort = 1'b0;

  int checks = 0, failures = 0;
  int low0, low3, oecnt0, stbcnt0;
  logic [7:0] last0, last3;

  always #5 clk = ~clk;

  bus_responder85 #(.MEMAW(8), .MEMBASE(16'h0000), .IOPORT(8'h10), .WAITCNT(0), .INTOP(8'hFF)) u_dut0 (
    .clk_(clk), .rst_(rst_), .a_hi(a_hi), .ad_i(ad_i), .ad_o(ad_o0), .ad_oe(ad_oe0), .ale(ale),
    .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_), .ready(ready0), .dev_in(dev_in),
    .dev_out(dev_out0), .dev_stb(dev_stb0));

  bus_responder85 #(.MEMAW(8), .MEMBASE(16'h0000), .IOPORT(8'h10), .WAITCNT(3), .INTOP(8'hFF)) u_dut3 (
    .clk_(clk), .rst_(rst_), .a_hi(a_hi), .ad_i(ad_i), .ad_o(ad_o3), .ad_oe(ad_oe3), .ale(ale),
    .iom_(iom_), .rd_(rd_), .wr_(wr_), .inta_(inta_), .ready(ready3), .dev_in(dev_in),
    .dev_out(dev_out3), .dev_stb(dev_stb3));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready0", {7'd0, ready0}, {7'd0, exp_rdy0});
      chk("ready3", {7'd0, ready3}, {7'd0, exp_rdy3});
      chk("ad_oe0", {7'd0, ad_oe0}, {7'd0, exp_oe0});
      chk("ad_oe3", {7'd0, ad_oe3}, {7'd0, exp_oe3});
      if (exp_oe0 && exp_known) chk("ad_o0", ad_o0, exp_data);
      if (exp_oe3 && exp_known) chk("ad_o3", ad_o3, exp_data);
      chk("dev_out0", dev_out0, exp_dev);
      chk("dev_out3", dev_out3, exp_dev);
      chk("dev_stb0", {7'd0, dev_stb0}, {7'd0, exp_stb});
      chk("dev_stb3", {7'd0, dev_stb3}, {7'd0, exp_stb});
      if (!ready0) low0++;
      if (!ready3) low3++;
      if (ad_oe0) begin oecnt0++; last0 = ad_o0; end
      if (ad_oe3) last3 = ad_o3;
      if (dev_stb0) stbcnt0++;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_rdy0 = 1'b1; exp_rdy3 = 1'b1; exp_oe0 = 1'b0; exp_oe3 = 1'b0; exp_stb = 1'b0;
  endtask

  task automatic idle();
    next();
    idle_exp();
  endtask

  task automatic clear_stats();
    low0 = 0; low3 = 0; oecnt0 = 0; stbcnt0 = 0; last0 = 8'h00; last3 = 8'h00;
  endtask

  // One CPU bus cycle: ALE period, strobe low for 'hold' clocks, release, one settle period.
  // With W wait states: READY low in periods 0..W-1, data drive from period max(W,1)+1.
  task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data, input bit abort_it);
    bit is_io, is_rd, is_wr, hit;
    int hold;
    is_io = (kind == K_IORD) || (kind == K_IOWR) || (kind == K_INTA);
    is_rd = (kind == K_MRD) || (kind == K_IORD) || (kind == K_INTA);
    is_wr = (kind == K_MWR) || (kind == K_IOWR);
    hit   = (kind == K_INTA) || (!is_io && addr[15:8] == 8'h00) || (is_io && addr[7:0] == 8'h10);
    hold  = $urandom_range(5, 8);

    next();
    ale = 1'b1; a_hi = addr[15:8]; ad_i = addr[7:0]; iom_ = is_io;
    if (!pend_abort) begin rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1; end
    pend_abort = 1'b0;
    idle_exp();
    clear_stats();
    exp_known = 1'b1;
    case (kind)
      K_MRD:   begin exp_data = ram[addr[7:0]]; exp_known = known[addr[7:0]]; end
      K_INTA:  exp_data = 8'hFF;
      default: exp_data = data;
    endcase

    for (int j = 0; j < hold; j++) begin
      next();
      if (j == 0) begin
        ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
        dev_in = data;
        ad_i = is_wr ? data : 8'($urandom);
        if (kind == K_MRD || kind == K_IORD) rd_ = 1'b0;
        else if (is_wr) wr_ = 1'b0;
        else inta_ = 1'b0;
      end
      exp_rdy0 = 1'b1;
      exp_rdy3 = !(hit && j < 3);
      exp_oe0  = hit && is_rd && j >= 2;
      exp_oe3  = hit && is_rd && j >= 4;
      exp_stb  = 1'b0;
    end
    if (abort_it) begin
      pend_abort = 1'b1;
      return;
    end

    next();
    rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
    exp_rdy3 = 1'b1;

    next();
    idle_exp();
    if (hit && kind == K_IOWR) begin exp_dev = data; exp_stb = 1'b1; end
    if (hit && kind == K_MWR) begin ram[addr[7:0]] = data; known[addr[7:0]] = 1'b1; end
  endtask

  initial begin
    int kind;
    logic [15:0] addr;
    bit ab;
    for (int i = 0; i < 256; i++) begin known[i] = 1'b0; ram[i] = 8'h00; end
    exp_dev = 8'h00; exp_data = 8'h00; exp_known = 1'b0;
    idle_exp();
    clear_stats();
    next();
    next();
    rst_ = 1'b1;
    chk_en = 1'b1;
    chk("rst_ad_o0", ad_o0, 8'h00);
    chk("rst_ad_o3", ad_o3, 8'h00);

    // Memory write then read at 0x0042
    bus_cycle(K_MWR, 16'h0042, 8'hA5, 1'b0);
    bus_cycle(K_MRD, 16'h0042, 8'h00, 1'b0);
    idle();
    chk("pin_rd0", last0, 8'hA5);
    chk("pin_rd3", last3, 8'hA5);
    chk("pin_low0", 8'(low0), 8'd0);
    chk("pin_low3", 8'(low3), 8'd3);

    // I/O write and read on port 0x10, then a miss on port 0x11
    bus_cycle(K_IOWR, 16'h1010, 8'h3C, 1'b0);
    idle();
    chk("pin_devout", dev_out0, 8'h3C);
    chk("pin_stbcnt", 8'(stbcnt0), 8'd1);
    bus_cycle(K_IORD, 16'h1010, 8'h5A, 1'b0);
    idle();
    chk("pin_iord", last0, 8'h5A);
    bus_cycle(K_IOWR, 16'h1111, 8'h99, 1'b0);
    idle();
    chk("pin_miss_dev", dev_out0, 8'h3C);
    chk("pin_miss_stb", 8'(stbcnt0), 8'd0);
    chk("pin_miss_oe", 8'(oecnt0), 8'd0);
    chk("pin_miss_low", 8'(low3), 8'd0);

    // Interrupt acknowledge
    bus_cycle(K_INTA, 16'h0042, 8'h00, 1'b0);
    idle();
    chk("pin_inta", last0, 8'hFF);

    // Write aborted by a new ALE keeps the old RAM byte
    bus_cycle(K_MWR, 16'h0042, 8'h77, 1'b1);
    bus_cycle(K_MRD, 16'h0042, 8'h00, 1'b0);
    idle();
    chk("pin_abort", last0, 8'hA5);
    chk("pin_abort3", last3, 8'hA5);

    // Reset while the WAITCNT=3 instance sits in its wait states
    next();
    ale = 1'b1; a_hi = 8'h00; ad_i = 8'h42; iom_ = 1'b0;
    idle_exp();
    next();
    ale = 1'b0; rd_ = 1'b0;
    exp_rdy3 = 1'b0;
    next();
    rst_ = 1'b0;
    next();
    rst_ = 1'b1; rd_ = 1'b1;
    exp_dev = 8'h00;
    idle_exp();
    idle();
    chk("pin_rst_dev", dev_out0, 8'h00);
    bus_cycle(K_MRD, 16'h0042, 8'h00, 1'b0);
    idle();
    chk("pin_rst_rd", last0, 8'hA5);
    chk("pin_rst_low3", 8'(low3), 8'd3);

    // Randomized traffic
    for (int i = 0; i < 160; i++) begin
      kind = $urandom_range(0, 4);
      addr[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      addr[7:0]  = ($urandom_range(0, 1) == 1) ? 8'h10 : 8'($urandom);
      ab = (kind == K_MWR || kind == K_IOWR) && ($urandom_range(0, 7) == 0) && (i != 159);
      bus_cycle(kind, addr, 8'($urandom), ab);
    end
    idle();
    idle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
